ghost_movement: RTL and testbench

GHOST_MOVEMENT -- requirements
Module: ghost_movement

---
 rtl/ghost_movement.sv | 170 +++++++++++++++++
 tb/tb_ghost_movement.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_movement.sv
// Ghost tile walker: probes the four neighbours, picks a direction, steps one tile.
// Optional GHOST_REVERSE_EN adds a reverse_req input that forces a U-turn at the next decision.
//
// state  | meaning
// IDLE   | after reset, one cycle before the first probe round
// PROBE  | reading neighbours L,R,U,D one at a time from the maze
// SETTLE | one cycle for the AI to see the fresh validDirection
// DECIDE | pick requested, continued or no direction
// MOVE   | advance ghost_offset on move_tick until the tile completes
module ghost_movement #(
  parameter int START_X    = 13,
  parameter int START_Y    = 11,
  parameter int GRID_W     = 28,
  parameter int GRID_H     = 31,
  parameter int TILE_STEPS = 8
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [3:0] BlinkyDirection,
`ifdef GHOST_REVERSE_EN
  input  logic       reverse_req,
`endif
  input  logic       wall_rd_valid,
  input  logic       wall_is_open,
  output logic       wall_rd_req,
  output logic [4:0] wall_addr_x,
  output logic [4:0] wall_addr_y,
  output logic [4:0] GhostPosition_x,
  output logic [4:0] GhostPosition_y,
  output logic [2:0] ghost_offset,
  output logic [3:0] validDirection,
  output logic [3:0] BlinkyDirActual,
  output logic       step_done
);

  localparam logic [4:0] X_MAX   = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
  localparam logic [4:0] X_START = 5'(START_X);
  localparam logic [4:0] Y_START = 5'(START_Y);
  localparam logic [2:0] OFF_MAX = 3'(TILE_STEPS - 1);

  typedef enum logic [2:0] {IDLE, PROBE, SETTLE, DECIDE, MOVE} state_t;

  state_t     state, state_nxt;
  logic [1:0] probe_idx;
  logic [3:0] open_acc;
  logic [3:0] last_dir;
  logic [3:0] choice;
  logic [3:0] probe_dir;
  logic       probe_blocked;
  logic       rd_done;
  logic       probe_step;
  logic       probe_bit;
  logic       last_probe;
  logic       tile_done;

  // Wrap is an explicit compare against the grid edge, not a 5-bit rollover.
  function automatic logic [4:0] step_x(input logic [4:0] x, input logic [3:0] d);
    if (d[0]) return (x == 5'd0) ? X_MAX : x - 5'd1;
    if (d[1]) return (x == X_MAX) ? 5'd0 : x + 5'd1;
    return x;
  endfunction

  function automatic logic [4:0] step_y(input logic [4:0] y, input logic [3:0] d);
    if (d[2]) return (y == 5'd0) ? y : y - 5'd1;
    if (d[3]) return (y == Y_MAX) ? y : y + 5'd1;
    return y;
  endfunction

  assign probe_dir     = 4'b0001 << probe_idx;
  assign probe_blocked = (probe_idx == 2'd2 && GhostPosition_y == 5'd0) ||
                         (probe_idx == 2'd3 && GhostPosition_y == Y_MAX);
  // A response only counts while our own request is outstanding.
  assign rd_done       = wall_rd_req && wall_rd_valid;
  assign probe_step    = (state == PROBE) && (rd_done || (!wall_rd_req && probe_blocked));
  assign probe_bit     = rd_done ? wall_is_open : 1'b0;
  assign last_probe    = probe_step && (probe_idx == 2'd3);
  assign tile_done     = (state == MOVE) && move_tick && (ghost_offset == OFF_MAX);

  assign BlinkyDirActual = (state == MOVE) ? last_dir : 4'b0000;

`ifdef GHOST_REVERSE_EN
  logic       rev_flag;
  logic [3:0] opp_dir;

  assign opp_dir = {last_dir[2], last_dir[3], last_dir[0], last_dir[1]};

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset)                rev_flag <= 1'b0;
    else if (state == DECIDE)  rev_flag <= reverse_req;
    else if (reverse_req)      rev_flag <= 1'b1;
  end
`endif

  always_comb begin
    choice = 4'b0000;
    if ($onehot(BlinkyDirection) && (BlinkyDirection & validDirection) != 4'b0000)
      choice = BlinkyDirection;
    else if ((last_dir & validDirection) != 4'b0000)
      choice = last_dir;
`ifdef GHOST_REVERSE_EN
    if (rev_flag && (opp_dir & validDirection) != 4'b0000)
      choice = opp_dir;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = PROBE;
      PROBE:   if (last_probe) state_nxt = SETTLE;
      SETTLE:  state_nxt = DECIDE;
      DECIDE:  state_nxt = (choice != 4'b0000) ? MOVE : PROBE;
      MOVE:    if (tile_done) state_nxt = PROBE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      probe_idx       <= 2'd0;
      open_acc        <= 4'b0000;
      validDirection  <= 4'b0000;
      last_dir        <= 4'b0000;
      wall_rd_req     <= 1'b0;
      wall_addr_x     <= 5'd0;
      wall_addr_y     <= 5'd0;
      GhostPosition_x <= X_START;
      GhostPosition_y <= Y_START;
      ghost_offset    <= 3'd0;
      step_done       <= 1'b0;
    end else begin
      step_done <= tile_done;
      case (state)
        PROBE: begin
          if (probe_step) begin
            wall_rd_req         <= 1'b0;
            open_acc[probe_idx] <= probe_bit;
            probe_idx           <= probe_idx + 2'd1;
            if (probe_idx == 2'd3) validDirection <= {probe_bit, open_acc[2:0]};
          end else if (!wall_rd_req) begin
            wall_rd_req <= 1'b1;
            wall_addr_x <= step_x(GhostPosition_x, probe_dir);
            wall_addr_y <= step_y(GhostPosition_y, probe_dir);
          end
        end
        DECIDE: begin
          if (choice != 4'b0000) last_dir <= choice;
        end
        MOVE: begin
          if (tile_done) begin
            ghost_offset    <= 3'd0;
            GhostPosition_x <= step_x(GhostPosition_x, last_dir);
            GhostPosition_y <= step_y(GhostPosition_y, last_dir);
          end else if (move_tick) begin
            ghost_offset <= ghost_offset + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_movement.sv
// Scoreboard bench for ghost_movement: expected probe addresses and tile positions
// are queued as stimulus is driven and compared as the DUT issues reads and steps.
module tb_ghost_movement;

  localparam int TILE_STEPS = 8;

  logic       clk_25mhz;
  logic       reset;
  logic       move_tick;
  logic [3:0] BlinkyDirection;
`ifdef GHOST_REVERSE_EN
  logic       reverse_req;
`endif
  logic       wall_rd_valid;
  logic       wall_is_open;
  logic       wall_rd_req;
  logic [4:0] wall_addr_x, wall_addr_y;
  logic [4:0] GhostPosition_x, GhostPosition_y;
  logic [2:0] ghost_offset;
  logic [3:0] validDirection;
  logic [3:0] BlinkyDirActual;
  logic       step_done;

  ghost_movement dut (
    .clk_25mhz       (clk_25mhz),
    .reset           (reset),
    .move_tick       (move_tick),
    .BlinkyDirection (BlinkyDirection),
`ifdef GHOST_REVERSE_EN
    .reverse_req     (reverse_req),
`endif
    .wall_rd_valid   (wall_rd_valid),
    .wall_is_open    (wall_is_open),
    .wall_rd_req     (wall_rd_req),
    .wall_addr_x     (wall_addr_x),
    .wall_addr_y     (wall_addr_y),
    .GhostPosition_x (GhostPosition_x),
    .GhostPosition_y (GhostPosition_y),
    .ghost_offset    (ghost_offset),
    .validDirection  (validDirection),
    .BlinkyDirActual (BlinkyDirActual),
    .step_done       (step_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_steps  = 0;
  int resp_delay = 2;
  int wait_cnt = 0;
  bit resp_en = 0;
  bit maze_open = 1;
  bit seen = 0;
  logic [9:0] held_a;
  logic [9:0] exp_a;
  logic [9:0] addr_q[$];
  logic [9:0] pos_q[$];

  initial begin
    clk_25mhz = 0;
    forever #20 clk_25mhz = ~clk_25mhz;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_probes(input logic [4:0] x, input logic [4:0] y);
    logic [4:0] lx, rx, uy, dy;
    lx = (x == 5'd0) ? 5'd27 : x - 5'd1;
    rx = (x == 5'd27) ? 5'd0 : x + 5'd1;
    uy = y - 5'd1;
    dy = y + 5'd1;
    addr_q.push_back({lx, y});
    addr_q.push_back({rx, y});
    if (y != 5'd0)  addr_q.push_back({x, uy});
    if (y != 5'd30) addr_q.push_back({x, dy});
  endtask

  // Maze responder: checks each new request address and holds it until answered.
  initial begin
    wall_rd_valid = 0;
    wall_is_open  = 0;
    forever begin
      @(negedge clk_25mhz);
      if (!resp_en || !reset) begin
        seen = 0;
        if (resp_en) wall_rd_valid = 0;
      end else begin
        wall_rd_valid = 0;
        if (wall_rd_req) begin
          if (!seen) begin
            seen = 1;
            wait_cnt = 0;
            n_reads++;
            held_a = {wall_addr_x, wall_addr_y};
            if (addr_q.size() > 0) begin
              exp_a = addr_q.pop_front();
              check("probe_addr", {wall_addr_x, wall_addr_y}, exp_a);
            end
          end else begin
            wait_cnt++;
            check("addr_hold", {wall_addr_x, wall_addr_y}, held_a);
          end
          if (wait_cnt >= resp_delay) begin
            wall_rd_valid = 1;
            wall_is_open  = maze_open;
            seen = 0;
          end
        end
      end
    end
  end

  // Step monitor: every step_done pops one expected tile position.
  initial begin
    forever begin
      @(negedge clk_25mhz);
      if (reset && step_done) begin
        n_steps++;
        check("step_expected", pos_q.size() > 0, 1);
        if (pos_q.size() > 0) begin
          exp_a = pos_q.pop_front();
          check("tile_pos", {GhostPosition_x, GhostPosition_y}, exp_a);
        end
      end
    end
  end

  task automatic do_tile(input logic [3:0] dir, input logic [4:0] nx, input logic [4:0] ny);
    int n;
    int s0;
    n = 0;
    while (BlinkyDirActual == 4'b0000 && n < 300) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("reach_move", n < 300, 1);
    check("dir_actual", BlinkyDirActual, dir);
    check("offset_start", ghost_offset, 0);
    push_probes(nx, ny);
    pos_q.push_back({nx, ny});
    s0 = n_steps;
    for (int i = 1; i <= TILE_STEPS; i++) begin
      move_tick = 1;
      @(negedge clk_25mhz);
      move_tick = 0;
      if (i < TILE_STEPS) begin
        @(negedge clk_25mhz);
        check("offset", ghost_offset, i);
        check("dir_hold", BlinkyDirActual, dir);
      end
    end
    check("offset_wrap", ghost_offset, 0);
    check("dir_after_tile", BlinkyDirActual, 0);
    @(negedge clk_25mhz);
    check("step_once", n_steps - s0, 1);
    check("step_pulse_len", step_done, 0);
  endtask

  initial begin
    int n, r0, s0, bad_dir, bad_off;
    reset = 1;
    move_tick = 0;
    BlinkyDirection = 4'b0010;
`ifdef GHOST_REVERSE_EN
    reverse_req = 0;
`endif
    #5 reset = 0;
    #1;
    check("rst_pos_x", GhostPosition_x, 13);
    check("rst_pos_y", GhostPosition_y, 11);
    check("rst_offset", ghost_offset, 0);
    check("rst_valid", validDirection, 0);
    check("rst_dir", BlinkyDirActual, 0);
    check("rst_req", wall_rd_req, 0);
    check("rst_step", step_done, 0);
    repeat (3) @(negedge clk_25mhz);

    // All-open probe round from reset, then one tile right.
    resp_en = 1;
    maze_open = 1;
    resp_delay = 2;
    push_probes(5'd13, 5'd11);
    r0 = n_reads;
    reset = 1;
    n = 0;
    while (validDirection == 4'b0000 && n < 200) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("probe_round_done", n < 200, 1);
    check("valid_all_open", validDirection, 4'b1111);
    check("dir_in_settle", BlinkyDirActual, 0);
    check("reads_round1", n_reads - r0, 4);
    check("addr_q_drained", addr_q.size(), 0);
    n = 0;
    while (BlinkyDirActual == 4'b0000 && n < 10) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("settle_decide_cycles", n, 2);
    check("valid_held_move", validDirection, 4'b1111);
    do_tile(4'b0010, 5'd14, 5'd11);
    check("pos_after_right", {GhostPosition_x, GhostPosition_y}, {5'd14, 5'd11});

    // Walk left to column 0, then wrap to column 27.
    BlinkyDirection = 4'b0001;
    for (int x = 14; x >= 1; x--) do_tile(4'b0001, 5'(x - 1), 5'd11);
    do_tile(4'b0001, 5'd27, 5'd11);
    check("wrap_x", GhostPosition_x, 27);

    // Everything closed: re-probe forever, no movement, ticks ignored.
    maze_open = 0;
    push_probes(5'd27, 5'd11);
    push_probes(5'd27, 5'd11);
    r0 = n_reads;
    s0 = n_steps;
    bad_dir = 0;
    bad_off = 0;
    move_tick = 1;
    repeat (160) begin
      @(negedge clk_25mhz);
      if (BlinkyDirActual != 4'b0000) bad_dir++;
      if (ghost_offset != 3'd0) bad_off++;
    end
    move_tick = 0;
    check("closed_dir_zero", bad_dir, 0);
    check("closed_offset_zero", bad_off, 0);
    check("closed_valid", validDirection, 4'b0000);
    check("closed_no_step", n_steps - s0, 0);
    check("closed_pos", {GhostPosition_x, GhostPosition_y}, {5'd27, 5'd11});
    check("closed_reprobe", (n_reads - r0) >= 8, 1);
    check("closed_addr_q", addr_q.size(), 0);

    // Reset in the middle of an unanswered read.
    resp_delay = 100000;
    n = 0;
    while (!wall_rd_req && n < 50) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("req_pending", wall_rd_req, 1);
    #5 reset = 0;
    #1;
    check("mid_rst_req", wall_rd_req, 0);
    check("mid_rst_addr", {wall_addr_x, wall_addr_y}, 0);
    check("mid_rst_pos", {GhostPosition_x, GhostPosition_y}, {5'd13, 5'd11});
    check("mid_rst_offset", ghost_offset, 0);
    check("mid_rst_valid", validDirection, 0);
    check("mid_rst_dir", BlinkyDirActual, 0);
    check("mid_rst_step", step_done, 0);
    resp_en = 0;
    addr_q.delete();
    @(negedge clk_25mhz);
    resp_delay = 2;
    maze_open = 1;
    BlinkyDirection = 4'b0010;
    push_probes(5'd13, 5'd11);
    wall_is_open = 1;
    wall_rd_valid = 1;
    reset = 1;
    repeat (2) @(negedge clk_25mhz);
    wall_rd_valid = 0;
    check("stale_valid_ignored", wall_rd_req, 1);
    check("stale_valid_no_update", validDirection, 0);
    resp_en = 1;
    n = 0;
    while (validDirection == 4'b0000 && n < 200) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("post_rst_round", n < 200, 1);
    check("post_rst_valid", validDirection, 4'b1111);
    check("post_rst_pos", {GhostPosition_x, GhostPosition_y}, {5'd13, 5'd11});
    do_tile(4'b0010, 5'd14, 5'd11);

`ifdef GHOST_REVERSE_EN
    reverse_req = 1;
    @(negedge clk_25mhz);
    reverse_req = 0;
    do_tile(4'b0001, 5'd13, 5'd11);
`else
    do_tile(4'b0010, 5'd15, 5'd11);
`endif

    check("final_pos_q", pos_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
